// File: rtl/s2p_pkg.sv
// Shared types and constants for the s2p_capture serial-to-parallel receiver.
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam int ERR_CNT_W   = 8;
    localparam int ERR_CNT_MAX = 255;

endpackage

// File: rtl/s2p_capture.sv
// LSB-first serial-to-parallel receiver with valid/ready output.
// Optional saturating error counter: define S2P_ERR_CNT_EN.
module s2p_capture
    import s2p_pkg::*;
#(
    parameter int BITS = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sin,
    input  logic            sin_vld,
    input  logic            eos,
    output logic [BITS-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            frm_err,
    output logic            ovf,
    output logic            busy
`ifdef S2P_ERR_CNT_EN
    ,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int CW = $clog2(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [BITS-1:0] r_shreg;
    logic [BITS-1:0] r_dout;
    logic            r_dout_valid;
    logic            r_frm_err;
    logic            r_ovf;

    logic            w_wr;
    logic            w_commit;
    logic            w_err;
    logic            w_last;
    logic            w_take;
    logic            w_ovf_ev;
    logic [BITS-1:0] w_word;

    assign w_last = (r_cnt == LAST);
    assign w_word = {sin, r_shreg[BITS-2:0]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_cnt_nx = r_cnt;
        w_wr     = 1'b0;
        w_commit = 1'b0;
        w_err    = 1'b0;
        if (sin_vld) begin
            unique case (r_state)
                IDLE: begin
                    if (eos) begin
                        w_err = 1'b1;
                    end else begin
                        w_wr     = 1'b1;
                        w_cnt_nx = CW'(1);
                        w_next   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (eos) begin
                        w_commit = w_last;
                        w_err    = !w_last;
                        w_cnt_nx = '0;
                        w_next   = IDLE;
                    end else if (w_last) begin
                        w_err    = 1'b1;
                        w_cnt_nx = '0;
                        w_next   = RESYNC;
                    end else begin
                        w_wr     = 1'b1;
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                RESYNC: begin
                    if (eos) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (r_state != IDLE);
        w_take   = w_commit && (!r_dout_valid || dout_ready);
        w_ovf_ev = w_commit && r_dout_valid && !dout_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shreg <= '0;
        end else begin
            r_cnt <= w_cnt_nx;
            if (w_wr) r_shreg[r_cnt] <= sin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frm_err    <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_frm_err <= w_err;
            r_ovf     <= w_ovf_ev;
            if (w_take) begin
                r_dout       <= w_word;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frm_err    = r_frm_err;
    assign ovf        = r_ovf;

`ifdef S2P_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [ERR_CNT_W:0]   w_sum;

    assign w_sum = {1'b0, r_err_cnt}
                 + {{ERR_CNT_W{1'b0}}, w_err}
                 + {{ERR_CNT_W{1'b0}}, w_ovf_ev};

    always_ff @(posedge clk) begin
        if (rst || err_clr)
            r_err_cnt <= '0;
        else if (w_sum > (ERR_CNT_W+1)'(ERR_CNT_MAX))
            r_err_cnt <= ERR_CNT_W'(ERR_CNT_MAX);
        else
            r_err_cnt <= w_sum[ERR_CNT_W-1:0];
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
